// File: rtl/seg_display_scanner.sv
// Eight-digit multiplexed hex display for the CPU observation outputs.
// The displayed value is latched once per frame so a live counter never tears across digits.
module seg_display_scanner #(
  parameter int SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        freeze,
  input  logic        lz_blank,
  input  logic [31:0] led_data_in,
  input  logic        led_cpu_enable,
  input  logic [31:0] total_cycles,
  input  logic [31:0] condi_branch_num,
  input  logic [31:0] uncondi_branch_num,
  input  logic [31:0] bubble_num,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  // Active-low g..a pattern for one hex nibble (dp excluded).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  logic [SCAN_DIV-1:0] div_q, div_d;
  logic [2:0]          idx_q, idx_d;
  logic [31:0]         snap_q, snap_d;
  logic [2:0]          mode_q, mode_d;
  logic                pend_q, pend_d;
  logic                blink_q, blink_d;
  logic [7:0]          an_q, an_d;
  logic [7:0]          seg_q, seg_d;

  logic                tick_s;
  logic                fb_s;
  logic [31:0]         src_s;
  logic [4:0]          shift_s;
  logic [3:0]          nib_s;
  logic                mode_valid_s;
  logic                blank_s;
  logic                dp_on_s;

  // Scan timing, frame snapshot and syscall indicator next-state.
  always_comb begin
    tick_s = (div_q == {SCAN_DIV{1'b1}});
    fb_s   = tick_s && (idx_q == 3'd7);
    div_d  = div_q + {{(SCAN_DIV-1){1'b0}}, 1'b1};
    if (tick_s) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end

    case (sel)
      3'd0:    src_s = led_data_in;
      3'd1:    src_s = total_cycles;
      3'd2:    src_s = condi_branch_num;
      3'd3:    src_s = uncondi_branch_num;
      3'd4:    src_s = bubble_num;
      default: src_s = 32'd0;
    endcase

    snap_d  = snap_q;
    mode_d  = mode_q;
    blink_d = blink_q;
    pend_d  = pend_q | led_cpu_enable;
    if (fb_s) begin
      // A pulse landing on the boundary cycle seeds the next pending window.
      blink_d = pend_q;
      pend_d  = led_cpu_enable;
      if (!freeze) begin
        snap_d = src_s;
        mode_d = sel;
      end else begin
        snap_d = snap_q;
        mode_d = mode_q;
      end
    end else begin
      blink_d = blink_q;
    end
  end

  // Digit decode, leading-zero blanking and decimal point for the current index.
  always_comb begin
    shift_s      = {idx_q, 2'b00};
    nib_s        = snap_q[shift_s +: 4];
    mode_valid_s = (mode_q <= 3'd4);
    blank_s      = lz_blank && mode_valid_s && (idx_q != 3'd0) &&
                   ((snap_q >> shift_s) == 32'd0);
    dp_on_s      = !mode_valid_s || ((idx_q == 3'd0) && blink_q);
    if (blank_s) begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end else begin
      an_d  = ~(8'b0000_0001 << idx_q);
      seg_d = {~dp_on_s, hex_to_seg(nib_s)};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= {SCAN_DIV{1'b0}};
      idx_q   <= 3'd0;
      snap_q  <= 32'd0;
      mode_q  <= 3'd0;
      pend_q  <= 1'b0;
      blink_q <= 1'b0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      blink_q <= blink_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with SCAN_DIV=2 (4-clock digits, 32-clock frames).
module tb_seg_display_scanner;

  localparam logic [63:0] AN_N = 64'h7FBF_DFEF_F7FB_FDFE;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic        freeze;
  logic        lz_blank;
  logic [31:0] led_data_in;
  logic        led_cpu_enable;
  logic [31:0] total_cycles;
  logic [31:0] condi_branch_num;
  logic [31:0] uncondi_branch_num;
  logic [31:0] bubble_num;
  logic [7:0]  an;
  logic [7:0]  seg;

  logic [31:0] tc_base;
  logic [31:0] tc_cnt = 32'd0;
  logic        tc_run;
  logic [31:0] cap_tc = 32'd0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_seg;

  seg_display_scanner #(.SCAN_DIV(2)) dut (
    .clk(clk), .rst(rst), .sel(sel), .freeze(freeze), .lz_blank(lz_blank),
    .led_data_in(led_data_in), .led_cpu_enable(led_cpu_enable),
    .total_cycles(total_cycles), .condi_branch_num(condi_branch_num),
    .uncondi_branch_num(uncondi_branch_num), .bubble_num(bubble_num),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Edges since reset release; frame n's snapshot edge is cycle 32n.
  always @(posedge clk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (tc_run) tc_cnt <= tc_cnt + 32'd1;
  end

  assign total_cycles = tc_base + tc_cnt;

  // Value of total_cycles presented at each frame-boundary edge.
  always @(posedge clk) begin
    if (rst && (cyc % 32 == 31)) cap_tc <= total_cycles;
  end

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'h0: c = 8'hC0; 4'h1: c = 8'hF9; 4'h2: c = 8'hA4; 4'h3: c = 8'hB0;
      4'h4: c = 8'h99; 4'h5: c = 8'h92; 4'h6: c = 8'h82; 4'h7: c = 8'hF8;
      4'h8: c = 8'h80; 4'h9: c = 8'h90; 4'hA: c = 8'h88; 4'hB: c = 8'h83;
      4'hC: c = 8'hC6; 4'hD: c = 8'hA1; 4'hE: c = 8'h86; 4'hF: c = 8'h8E;
      default: c = 8'hFF;
    endcase
    return c;
  endfunction

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Called at the negedge right after a boundary edge; checks every sample of the frame.
  task automatic check_frame(input string tag, input logic [63:0] e_an, input logic [63:0] e_seg);
    for (int d = 0; d < 8; d++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        check_eq($sformatf("%s an d%0d s%0d", tag, d, s), an, e_an[8*d +: 8]);
        check_eq($sformatf("%s seg d%0d s%0d", tag, d, s), seg, e_seg[8*d +: 8]);
      end
    end
  endtask

  task automatic next_frame();
    @(negedge clk);
    for (int i = 0; i < 64 && (cyc % 32) != 0; i++) @(negedge clk);
    if ((cyc % 32) != 0) check_eq("next_frame_timeout", 8'd1, 8'd0);
  endtask

  task automatic build_seg(input logic [31:0] v);
    for (int d = 0; d < 8; d++) exp_seg[8*d +: 8] = hex_seg(v[4*d +: 4]);
  endtask

  initial begin
    rst = 1'b0; sel = 3'd0; freeze = 1'b0; lz_blank = 1'b0;
    led_data_in = 32'd0; led_cpu_enable = 1'b0; tc_base = 32'd0; tc_run = 1'b0;
    condi_branch_num = 32'd0; uncondi_branch_num = 32'd0; bubble_num = 32'd0;

    // Reset and the first frame of snap=0.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst an", an, 8'hFF);
      check_eq("rst seg", seg, 8'hFF);
    end
    rst = 1'b1;
    check_frame("frame0", AN_N, 64'hC0C0_C0C0_C0C0_C0C0);

    led_data_in = 32'h89AB_CDEF;
    next_frame();
    check_frame("hex", AN_N, 64'h8090_8883_C6A1_868E);

    // Live counter must appear as one consistent value per frame.
    sel = 3'd1; tc_base = 32'h1234_FFE0; tc_run = 1'b1;
    next_frame();
    build_seg(cap_tc);
    check_frame("tear1", AN_N, exp_seg);
    build_seg(cap_tc);
    check_frame("tear2", AN_N, exp_seg);
    tc_run = 1'b0;

    sel = 3'd0; lz_blank = 1'b1; led_data_in = 32'h0000_0A30;
    next_frame();
    check_frame("blank_a30", 64'hFFFF_FFFF_FFFB_FDFE, 64'hFFFF_FFFF_FF88_B0C0);
    led_data_in = 32'd0;
    next_frame();
    check_frame("blank_zero", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0);
    lz_blank = 1'b0;

    led_data_in = 32'h1234_5678;
    next_frame();
    check_frame("frz_base", AN_N, 64'hF9A4_B099_9282_F880);
    freeze = 1'b1; sel = 3'd2; condi_branch_num = 32'hDEAD_BEEF; led_data_in = 32'hCAFE_F00D;
    check_frame("frz1", AN_N, 64'hF9A4_B099_9282_F880);
    sel = 3'd6; bubble_num = 32'h0000_0042;
    check_frame("frz2", AN_N, 64'hF9A4_B099_9282_F880);
    sel = 3'd3; uncondi_branch_num = 32'h7777_0001;
    check_frame("frz3", AN_N, 64'hF9A4_B099_9282_F880);
    freeze = 1'b0; sel = 3'd2;
    next_frame();
    check_frame("unfrz", AN_N, 64'hA186_88A1_8386_868E);

    // Invalid source: zero value, dp lit on every digit, never blanked.
    sel = 3'd6; lz_blank = 1'b1;
    next_frame();
    check_frame("invalid", AN_N, 64'h4040_4040_4040_4040);

    sel = 3'd0; led_data_in = 32'd0;
    next_frame();
    repeat (10) @(negedge clk);
    led_cpu_enable = 1'b1;
    @(negedge clk);
    led_cpu_enable = 1'b0;
    next_frame();
    check_frame("dp_mid", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF40);
    check_frame("dp_off", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0);
    for (int i = 0; i < 64 && (cyc % 32) != 31; i++) @(negedge clk);
    led_cpu_enable = 1'b1;
    @(negedge clk);
    led_cpu_enable = 1'b0;
    check_frame("dp_fb_wait", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFC0);
    check_frame("dp_fb_lit", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FF40);

    // Reset in the middle of a frame restarts scanning from digit 0 with snap 0.
    lz_blank = 1'b0; led_data_in = 32'hDEAD_BEEF;
    next_frame();
    repeat (9) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("midrst an", an, 8'hFF);
      check_eq("midrst seg", seg, 8'hFF);
    end
    rst = 1'b1;
    check_frame("post_rst", AN_N, 64'hC0C0_C0C0_C0C0_C0C0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
